alu_seq: RTL and testbench

//  Sequential, parametrised successor to the combinational 8-bit ALU of the Salamander-4 datapath.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake, registered Z/N/C/V flags and
// multi-cycle shifts/rotates (one bit per cycle).
//
// state | meaning
// IDLE  | waiting for an op; in_ready follows CE
// SHIFT | operands captured; shifting while cnt>0, evaluates when cnt==0
// DONE  | result and flags held, out_valid=1 until out_ready
module alu_seq #(
  parameter int SIZE = 8,
  parameter int SHW  = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            CE,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      OP_CODE,
  input  logic [SIZE-1:0] left_operand,
  input  logic [SIZE-1:0] right_operand,
  input  logic            carry_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] op_out,
  output logic            carry_out,
  output logic            zero_out,
  output logic            neg_out,
  output logic            ovf_out,
  output logic            busy
);

  localparam int M = SIZE - 1;
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [SIZE-1:0] work_q, work_d, r_q, r_d, res_q, res_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            cin_q, cin_d, cbit_q, cbit_d;
  logic            c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;

  logic            accept, is_shift, r_msb;
  logic [SIZE:0]   l_x, r_x, cin_x, one_x, ext;
  logic [SIZE-1:0] alu_res;
  logic            alu_c, alu_v;

  assign in_ready  = (state_q == IDLE) & CE;
  assign accept    = in_valid & in_ready;
  assign is_shift  = (OP_CODE[3:2] == 2'b11);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign op_out    = res_q;
  assign carry_out = c_q;
  assign zero_out  = z_q;
  assign neg_out   = n_q;
  assign ovf_out   = v_q;

  // work_q doubles as operand L; for shift ops it already holds the shifted value
  always_comb begin
    l_x   = {1'b0, work_q};
    r_x   = {1'b0, r_q};
    cin_x = {{SIZE{1'b0}}, cin_q};
    one_x = {{SIZE{1'b0}}, 1'b1};
    ext   = l_x;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      4'h0:    ext = l_x + r_x;
      4'h1:    ext = l_x + r_x + cin_x;
      4'h2:    ext = l_x - r_x;
      4'h3:    ext = l_x - r_x - cin_x;
      4'h4:    ext = l_x & r_x;
      4'h5:    ext = l_x | r_x;
      4'h6:    ext = l_x ^ r_x;
      4'h7:    ext = {1'b0, ~work_q};
      4'h8:    ext = r_x;
      4'hA:    ext = l_x + one_x;
      4'hB:    ext = l_x - one_x;
      default: ext = l_x;
    endcase
    alu_res = ext[SIZE-1:0];
    // INC/DEC behave as add/sub of a positive constant, so its sign bit is 0
    r_msb = op_q[3] ? 1'b0 : r_q[M];
    case (op_q)
      4'h0, 4'h1, 4'hA: begin
        alu_c = ext[SIZE];
        alu_v = (work_q[M] == r_msb) & (alu_res[M] != work_q[M]);
      end
      4'h2, 4'h3, 4'hB: begin
        alu_c = ext[SIZE];
        alu_v = (work_q[M] != r_msb) & (alu_res[M] != work_q[M]);
      end
      4'hC, 4'hD, 4'hE, 4'hF: alu_c = cbit_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    r_d     = r_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    cbit_d  = cbit_q;
    res_d   = res_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = OP_CODE;
          work_d  = left_operand;
          r_d     = right_operand;
          cin_d   = carry_in;
          cbit_d  = 1'b0;
          cnt_d   = is_shift ? right_operand[SHW-1:0] : '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
          case (op_q[1:0])
            2'b00: begin cbit_d = work_q[M]; work_d = {work_q[SIZE-2:0], 1'b0};      end
            2'b01: begin cbit_d = work_q[0]; work_d = {1'b0, work_q[SIZE-1:1]};      end
            2'b10: begin cbit_d = work_q[M]; work_d = {work_q[SIZE-2:0], work_q[M]}; end
            default: begin cbit_d = work_q[0]; work_d = {work_q[0], work_q[SIZE-1:1]}; end
          endcase
        end else begin
          res_d   = alu_res;
          c_d     = alu_c;
          v_d     = alu_v;
          z_d     = (alu_res == '0);
          n_d     = alu_res[M];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      r_q     <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      cbit_q  <= 1'b0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      r_q     <= r_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      cbit_q  <= cbit_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, corner-case sequences and
// random ops compared against an arithmetic reference model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst, CE, in_valid, in_ready, carry_in;
  logic       out_valid, out_ready, carry_out, zero_out, neg_out, ovf_out, busy;
  logic [3:0] OP_CODE;
  logic [7:0] left_operand, right_operand, op_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_seq #(.SIZE(8)) dut (
    .clk(clk), .rst(rst), .CE(CE), .in_valid(in_valid), .in_ready(in_ready),
    .OP_CODE(OP_CODE), .left_operand(left_operand), .right_operand(right_operand),
    .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
    .op_out(op_out), .carry_out(carry_out), .zero_out(zero_out),
    .neg_out(neg_out), .ovf_out(ovf_out), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] l;
    logic [7:0] r;
    logic       cin;
    logic [7:0] res;
    logic [3:0] flg;   // {C, Z, N, V}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic, whole shift amount at once
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] l,
                                        input logic [7:0] r, input logic cin);
    int li, ri, ci, ls, rs, k, s, ss;
    logic [7:0] res;
    logic c, v;
    li = l; ri = r; ci = cin; ls = $signed(l); rs = $signed(r);
    k = ri % 8; c = 1'b0; v = 1'b0; res = 8'h00;
    case (op)
      4'h0: begin s = li + ri;      ss = ls + rs;      c = (s > 255); v = (ss > 127) || (ss < -128); res = 8'(s); end
      4'h1: begin s = li + ri + ci; ss = ls + rs + ci; c = (s > 255); v = (ss > 127) || (ss < -128); res = 8'(s); end
      4'h2: begin s = li - ri;      ss = ls - rs;      c = (li < ri);      v = (ss > 127) || (ss < -128); res = 8'(s); end
      4'h3: begin s = li - ri - ci; ss = ls - rs - ci; c = (li < ri + ci); v = (ss > 127) || (ss < -128); res = 8'(s); end
      4'h4: res = l & r;
      4'h5: res = l | r;
      4'h6: res = l ^ r;
      4'h7: res = ~l;
      4'h8: res = r;
      4'h9: res = l;
      4'hA: begin res = 8'(li + 1); c = (li == 255); v = (ls == 127);  end
      4'hB: begin res = 8'(li - 1); c = (li == 0);   v = (ls == -128); end
      4'hC: begin res = 8'(li << k); c = (k != 0) && (((li >> (8 - k)) & 1) == 1); end
      4'hD: begin res = 8'(li >> k); c = (k != 0) && (((li >> (k - 1)) & 1) == 1); end
      4'hE: begin res = (k == 0) ? l : 8'((li << k) | (li >> (8 - k))); c = (k != 0) && res[0]; end
      default: begin res = (k == 0) ? l : 8'((li >> k) | (li << (8 - k))); c = (k != 0) && res[7]; end
    endcase
    return {res, c, (res == 8'h00), res[7], v};
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [7:0] r);
    int k;
    k = int'(r) % 8;
    return (op >= 4'hC && k != 0) ? k + 1 : 1;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] l, input logic [7:0] r,
                        input logic cin, input int hold,
                        output logic [7:0] res, output logic [3:0] flg, output int lat);
    int g;
    @(negedge clk);
    OP_CODE = op; left_operand = l; right_operand = r; carry_in = cin;
    in_valid = 1'b1; out_ready = 1'b0;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      check("busy_in_flight", busy, 1);
      check("in_ready_in_flight", in_ready, 0);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    res = op_out;
    flg = {carry_out, zero_out, neg_out, ovf_out};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_data", op_out, res);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vt[16];
    logic [7:0] res;
    logic [3:0] flg;
    logic [11:0] m;
    int         lat;
    logic [3:0] rop;
    logic [7:0] rl, rr;
    logic       rc;

    vt[0]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100};
    vt[1]  = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011};
    vt[2]  = '{4'h2, 8'h01, 8'h02, 1'b0, 8'hFF, 4'b1010};
    vt[3]  = '{4'h3, 8'h05, 8'h02, 1'b1, 8'h02, 4'b0000};
    vt[4]  = '{4'hC, 8'h10, 8'h03, 1'b0, 8'h80, 4'b0010};
    vt[5]  = '{4'hD, 8'h81, 8'h01, 1'b0, 8'h40, 4'b1000};
    vt[6]  = '{4'hE, 8'h81, 8'h01, 1'b0, 8'h03, 4'b1000};
    vt[7]  = '{4'hA, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b1100};
    vt[8]  = '{4'hB, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b1010};
    vt[9]  = '{4'hC, 8'h5A, 8'hF8, 1'b0, 8'h5A, 4'b0000};
    vt[10] = '{4'hF, 8'h01, 8'h01, 1'b0, 8'h80, 4'b1010};
    vt[11] = '{4'h4, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
    vt[12] = '{4'h2, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001};
    vt[13] = '{4'h1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100};
    vt[14] = '{4'h7, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0010};
    vt[15] = '{4'h8, 8'h11, 8'h22, 1'b1, 8'h22, 4'b0000};

    rst = 1'b1; CE = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    OP_CODE = 4'h0; left_operand = 8'h00; right_operand = 8'h00; carry_in = 1'b0;
    #1;
    check("reset_op_out", op_out, 0);
    check("reset_flags", {carry_out, zero_out, neg_out, ovf_out}, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vt[i].op, vt[i].l, vt[i].r, vt[i].cin, 0, res, flg, lat);
      check($sformatf("vec%0d_result", i), res, vt[i].res);
      check($sformatf("vec%0d_flags", i), flg, vt[i].flg);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vt[i].op, vt[i].r));
    end

    // result held while consumer stalls; next op accepted right after release
    run_op(4'h4, 8'hFF, 8'h55, 1'b0, 5, res, flg, lat);
    check("stall_result", res, 8'h55);
    check("release_in_ready", in_ready, 1);
    check("release_busy", busy, 0);
    run_op(4'h6, 8'hAA, 8'h0F, 1'b0, 0, res, flg, lat);
    check("after_release_result", res, 8'hA5);
    check("after_release_latency", lat, 1);

    // CE low while idle: no acceptance
    @(negedge clk); CE = 1'b0; OP_CODE = 4'h0; in_valid = 1'b1;
    #1 check("ce_idle_in_ready", in_ready, 0);
    @(posedge clk); #1 check("ce_idle_busy", busy, 0);
    @(negedge clk); in_valid = 1'b0; CE = 1'b1;

    // CE low for 3 cycles during SHL k=4 stretches latency to 8
    @(negedge clk);
    OP_CODE = 4'hC; left_operand = 8'h10; right_operand = 8'h04; carry_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk); CE = (lat >= 1 && lat <= 3) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("ce_stall_latency", lat, 8);
    check("ce_stall_result", op_out, 8'h00);
    check("ce_stall_flags", {carry_out, zero_out, neg_out, ovf_out}, 4'b1100);
    @(negedge clk); CE = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 check("ce_done_hold", out_valid, 1);
    @(negedge clk); CE = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("ce_done_release", busy, 0);

    // reset in the middle of a shift discards the op
    run_op(4'h5, 8'hA0, 8'h05, 1'b0, 0, res, flg, lat);
    check("pre_reset_result", res, 8'hA5);
    @(negedge clk);
    OP_CODE = 4'hC; left_operand = 8'h01; right_operand = 8'h07; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("midshift_reset_op_out", op_out, 0);
    check("midshift_reset_flags", {carry_out, zero_out, neg_out, ovf_out}, 0);
    check("midshift_reset_out_valid", out_valid, 0);
    check("midshift_reset_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    run_op(4'hA, 8'hFF, 8'h00, 1'b0, 0, res, flg, lat);
    check("post_reset_inc_result", res, 8'h00);
    check("post_reset_inc_flags", flg, 4'b1100);
    check("post_reset_inc_latency", lat, 1);

    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      rl  = 8'($urandom_range(0, 255));
      rr  = 8'($urandom_range(0, 255));
      rc  = 1'($urandom_range(0, 1));
      m = model(rop, rl, rr, rc);
      run_op(rop, rl, rr, rc, 0, res, flg, lat);
      check($sformatf("rand%0d_op%0h_result", i, rop), res, m[11:4]);
      check($sformatf("rand%0d_op%0h_flags", i, rop), flg, m[3:0]);
      check($sformatf("rand%0d_op%0h_latency", i, rop), lat, exp_lat(rop, rr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
